// File: rtl/burst_rr_sched_if.sv
// Requester-side and downstream handshake bundle for burst_rr_sched.
// The slave modport is the scheduler; the master modport is the surrounding logic.
interface burst_rr_sched_if #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32
);
  localparam int IdxW = $clog2(NumIn);

  logic [NumIn-1:0]                req_i;
  logic [NumIn-1:0]                last_i;
  logic [NumIn-1:0][DataWidth-1:0] data_i;
  logic [NumIn-1:0]                gnt_o;
  logic                            req_o;
  logic [DataWidth-1:0]            data_o;
  logic                            last_o;
  logic [IdxW-1:0]                 idx_o;
  logic                            gnt_i;
  logic                            busy_o;

  modport master (
    output req_i, last_i, data_i, gnt_i,
    input  gnt_o, req_o, data_o, last_o, idx_o, busy_o
  );

  modport slave (
    input  req_i, last_i, data_i, gnt_i,
    output gnt_o, req_o, data_o, last_o, idx_o, busy_o
  );
endinterface

// File: rtl/burst_rr_sched.sv
// Burst-aware round-robin scheduler: a winner holds the shared port until last_i
// or MaxBurst beats, then priority rotates past it. Output stage is registered.
module burst_rr_sched #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  burst_rr_sched_if.slave   bus
);
  localparam int IdxW = $clog2(NumIn);
  localparam int CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q;
  logic [IdxW-1:0]      owner_q;
  logic [IdxW-1:0]      ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 vld_q;
  logic [DataWidth-1:0] data_q;
  logic                 last_q;
  logic [IdxW-1:0]      idx_q;

  logic                 lock_q;
  logic [IdxW-1:0]      winner;
  logic [IdxW:0]        cand;
  logic [IdxW-1:0]      sel;
  logic [IdxW-1:0]      ptr_next;
  logic                 act;
  logic                 rdy;
  logic                 acc;
  logic                 end_burst;
  logic [NumIn-1:0]     gnt;

  // Scan from the highest offset down so the lowest offset from ptr_q wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (IdxW + 1)'(i);
      if (cand >= (IdxW + 1)'(NumIn)) cand = cand - (IdxW + 1)'(NumIn);
      if (bus.req_i[cand[IdxW-1:0]]) winner = cand[IdxW-1:0];
    end
  end

  assign lock_q    = (state_q == LOCKED);
  assign sel       = lock_q ? owner_q : winner;
  assign act       = lock_q ? bus.req_i[owner_q] : |bus.req_i;
  assign rdy       = ~vld_q | bus.gnt_i;
  assign acc       = act & rdy;
  assign end_burst = acc & (bus.last_i[sel] | (cnt_q == CntW'(MaxBurst - 1)));
  assign ptr_next  = (sel == IdxW'(NumIn - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    gnt      = '0;
    gnt[sel] = acc;
  end

  // Burst FSM, rotation pointer and output register share one clocked block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc && !end_burst) begin
            state_q <= LOCKED;
            owner_q <= sel;
            cnt_q   <= CntW'(1);
          end
        end
        LOCKED: begin
          if (end_burst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (acc) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (end_burst) ptr_q <= ptr_next;

      if (acc) begin
        vld_q  <= 1'b1;
        data_q <= bus.data_i[sel];
        last_q <= bus.last_i[sel];
        idx_q  <= sel;
      end else if (bus.gnt_i) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.gnt_o  = gnt;
  assign bus.req_o  = vld_q;
  assign bus.data_o = data_q;
  assign bus.last_o = last_q;
  assign bus.idx_o  = idx_q;
  assign bus.busy_o = lock_q;
endmodule

// File: tb/tb_burst_rr_sched.sv
// Scoreboard bench for burst_rr_sched: directed steps with hand-derived grants,
// downstream beats checked by an independent monitor.
module tb_burst_rr_sched;
  localparam int NumIn     = 4;
  localparam int DataWidth = 32;
  localparam int MaxBurst  = 4;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
    logic [1:0]           idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  burst_rr_sched_if #(.NumIn(NumIn), .DataWidth(DataWidth)) bus ();

  burst_rr_sched #(.NumIn(NumIn), .DataWidth(DataWidth), .MaxBurst(MaxBurst)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  beat_t       sb[$];
  int          total = 0;
  int          fails = 0;
  logic [15:0] beat_cnt[NumIn];
  logic [31:0] held;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic refresh_data();
    for (int k = 0; k < NumIn; k++)
      bus.data_i[k] = {16'hD000 + 16'(k), beat_cnt[k]};
  endtask

  // Drive one cycle of inputs, check the same-cycle grant and busy, queue the expected beat.
  task automatic step(input logic [3:0] req, input logic [3:0] last, input logic dn,
                      input logic [3:0] exp_gnt, input logic exp_busy, input string nm);
    int    k;
    beat_t b;
    bus.req_i  = req;
    bus.last_i = last;
    bus.gnt_i  = dn;
    @(negedge clk);
    check({nm, "_gnt"}, 64'(bus.gnt_o), 64'(exp_gnt));
    check({nm, "_busy"}, 64'(bus.busy_o), 64'(exp_busy));
    k = -1;
    for (int i = 0; i < NumIn; i++) if (exp_gnt[i]) k = i;
    if (k >= 0) begin
      b.data = bus.data_i[k];
      b.last = last[k];
      b.idx  = 2'(k);
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    if (k >= 0) begin
      beat_cnt[k] = beat_cnt[k] + 16'd1;
      refresh_data();
    end
  endtask

  // Downstream monitor: every transfer on the output port must match the queue head.
  initial begin
    beat_t got;
    beat_t exp;
    forever begin
      @(negedge clk);
      if (rst_n && bus.req_o && bus.gnt_i) begin
        got.data = bus.data_o;
        got.last = bus.last_o;
        got.idx  = bus.idx_o;
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp = sb.pop_front();
          check("beat", 64'(got), 64'(exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NumIn; k++) beat_cnt[k] = 16'd0;
    refresh_data();
    rst_n      = 1'b0;
    flush      = 1'b0;
    bus.req_i  = '0;
    bus.last_i = '0;
    bus.gnt_i  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_o", 64'(bus.req_o), 64'd0);
    check("rst_data_o", 64'(bus.data_o), 64'd0);
    check("rst_last_o", 64'(bus.last_o), 64'd0);
    check("rst_idx_o", 64'(bus.idx_o), 64'd0);
    check("rst_busy_o", 64'(bus.busy_o), 64'd0);
    check("rst_gnt_o", 64'(bus.gnt_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round robin with single-beat grants.
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, "rr0");
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, "rr1");
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0, "rr2");
    step(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0, "rr3");
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, "rr4");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "rr_drain");

    // Move priority back to 0, then a 3-beat burst from req0 with req1 waiting.
    step(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, "pre_lock");
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, "lock_b1");
    step(4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, "lock_b2");
    step(4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, "lock_b3");
    step(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, "lock_next");

    // req2 streams without last; the cap ends it after 4 beats and req3 follows.
    step(4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b0, "cap_b1");
    step(4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, "cap_b2");
    step(4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, "cap_b3");
    step(4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, "cap_b4");
    check("cap_ptr", 64'(dut.ptr_q), 64'd3);
    step(4'b1100, 4'b1000, 1'b1, 4'b1000, 1'b0, "cap_next");
    step(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0, "cap_rearb");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "cap_drain");

    // Back-pressure: output full and downstream not ready.
    step(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, "bp_fill");
    held = {16'hD001, beat_cnt[1] - 16'd1};
    step(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, "bp_stall1");
    check("bp_data_hold1", 64'(bus.data_o), 64'(held));
    check("bp_req_o1", 64'(bus.req_o), 64'd1);
    step(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, "bp_stall2");
    check("bp_data_hold2", 64'(bus.data_o), 64'(held));
    step(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, "bp_release");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "bp_drain");

    // Owner stall: req0 locks, drops its request, req1 must keep waiting.
    step(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, "stall_b1");
    step(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b1, "stall_gap1");
    step(4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b1, "stall_gap2");
    step(4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, "stall_b2");
    step(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, "stall_next");

    // Flush while locked with a full output register.
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, "fl_lock");
    bus.req_i  = '0;
    bus.last_i = '0;
    bus.gnt_i  = 1'b0;
    flush      = 1'b1;
    @(negedge clk);
    check("fl_gnt", 64'(bus.gnt_o), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("fl_busy", 64'(bus.busy_o), 64'd0);
    check("fl_req_o", 64'(bus.req_o), 64'd0);
    @(posedge clk);
    #1;
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, "fl_restart");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "fl_drain");

    // Asynchronous reset while locked with a full output register.
    step(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, "rs_lock");
    bus.req_i = '0;
    bus.gnt_i = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rs_busy", 64'(bus.busy_o), 64'd0);
    check("rs_req_o", 64'(bus.req_o), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, "rs_restart");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "rs_drain");

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
